instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 21 ++
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Program-load byte stream between a loader (master) and instr_fetch (slave).
interface instr_fetch_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: 32 x 8 instruction store with program-load mode and a
// two-cycle FETCH/EXEC sequencer driving a downstream controller.
// Instruction format: opcode = [7:5], operand address = [4:0].
// Optional feature macro: SINGLE_STEP_EN adds a 'step' input; FETCH then
// waits for step = 1 so each pulse advances exactly one instruction.
module instr_fetch (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_start,
  instr_fetch_if.slave  load,
  input  logic          run,
  input  logic          acc_zero,
`ifdef SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic          Load_in,
  output logic [2:0]    Opcode,
  output logic [4:0]    Addr,
  output logic [4:0]    pc,
  output logic          halted
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    EXEC,
    HALT
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t     state;
  logic [7:0] mem [32];
  logic [7:0] ir;
  logic [4:0] wptr;
  logic       write_en;
  logic       fetch_go;

`ifdef SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  assign write_en = (state == LOAD) && load.load_valid;
  assign Addr     = ir[4:0];

  // Instruction store; deliberately not reset so a program survives reset.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[wptr] <= load.load_data;
    end
  end

  // Sequencer: load/fetch/execute control with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      pc              <= '0;
      ir              <= '0;
      wptr            <= '0;
      Load_in         <= 1'b0;
      load.load_ready <= 1'b0;
      Opcode          <= '0;
      halted          <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (prog_start) begin
            state           <= LOAD;
            wptr            <= '0;
            Load_in         <= 1'b1;
            load.load_ready <= 1'b1;
            halted          <= 1'b0;
          end else if (run) begin
            state  <= FETCH;
            pc     <= '0;
            halted <= 1'b0;
          end
        end

        LOAD: begin
          if (load.load_valid) begin
            wptr <= wptr + 5'd1;
            // Leave on the marked last byte or once slot 31 is written,
            // so the pointer wrap never overwrites slot 0.
            if (load.load_last || (wptr == 5'd31)) begin
              state           <= IDLE;
              Load_in         <= 1'b0;
              load.load_ready <= 1'b0;
            end
          end
        end

        FETCH: begin
          if (fetch_go) begin
            ir     <= mem[pc];
            // Opcode is registered here so it is valid for the whole EXEC
            // cycle and stable at the edge where the controller samples it.
            Opcode <= mem[pc][7:5];
            state  <= EXEC;
          end
        end

        EXEC: begin
          Opcode <= '0;
          case (ir[7:5])
            OP_HLT: begin
              state  <= HALT;
              halted <= 1'b1;
            end
            OP_JMP: begin
              pc    <= ir[4:0];
              state <= FETCH;
            end
            OP_SKZ: begin
              pc    <= acc_zero ? (pc + 5'd2) : (pc + 5'd1);
              state <= FETCH;
            end
            default: begin
              pc    <= pc + 5'd1;
              state <= FETCH;
            end
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the driver loads programs and runs them,
// pushing expectations from an instruction-level reference model; a negedge
// monitor pops and compares whenever the DUT shows a load beat, an executing
// opcode, or a newly raised halt.
module tb_instr_fetch;

  logic       clock      = 1'b0;
  logic       reset      = 1'b0;
  logic       prog_start = 1'b0;
  logic       run        = 1'b0;
  logic       acc_zero   = 1'b0;
  logic       Load_in;
  logic [2:0] Opcode;
  logic [4:0] Addr;
  logic [4:0] pc;
  logic       halted;

  instr_fetch_if bus ();

  always #5 clock = ~clock;

  instr_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .prog_start (prog_start),
    .load       (bus),
    .run        (run),
    .acc_zero   (acc_zero),
`ifdef SINGLE_STEP_EN
    .step       (1'b1),
`endif
    .Load_in    (Load_in),
    .Opcode     (Opcode),
    .Addr       (Addr),
    .pc         (pc),
    .halted     (halted)
  );

  typedef struct {
    logic [2:0] op;
    logic [4:0] addr;
    logic [4:0] pc;
  } exec_t;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  exec_t       exp_q[$];
  bit          ld_q[$];
  logic [7:0]  ref_mem [32];
  logic        prev_halted = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Instruction-level reference: walk the program from address 0.
  task automatic iss(input logic [7:0] m [32], input bit az, input int maxn,
                     output exec_t tr[$], output bit halts);
    int         p;
    logic [7:0] b;
    exec_t      r;
    p     = 0;
    tr    = {};
    halts = 1'b0;
    for (int n = 0; n < maxn; n++) begin
      b      = m[p];
      r.op   = b[7:5];
      r.addr = b[4:0];
      r.pc   = 5'(p);
      tr.push_back(r);
      if (r.op == 3'd0) begin
        halts = 1'b1;
        break;
      end else if (r.op == 3'd7) begin
        p = int'(b[4:0]);
      end else if (r.op == 3'd1) begin
        p = (p + (az ? 2 : 1)) % 32;
      end else begin
        p = (p + 1) % 32;
      end
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge clock) begin
    exec_t r;
    bit    e;
    if (bus.load_valid) begin
      if (ld_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL load_unexpected: beat with no expectation at %0t", $time);
      end else begin
        e = ld_q.pop_front();
        chk("load_ready", bus.load_ready, e);
        chk("Load_in", Load_in, e);
      end
    end
    if ((Opcode != 3'd0) || (halted && !prev_halted)) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL exec_unexpected: Opcode %0h halted %0b at %0t", Opcode, halted, $time);
      end else begin
        r = exp_q.pop_front();
        chk("Opcode", Opcode, r.op);
        chk("Addr", Addr, r.addr);
        chk("pc", pc, r.pc);
      end
    end
    prev_halted = halted;
  end

  task automatic do_reset();
    tick();
    prog_start     = 1'b0;
    run            = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_Load_in", Load_in, 0);
    chk("rst_load_ready", bus.load_ready, 0);
    chk("rst_Opcode", Opcode, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_Addr", Addr, 0);
    #1;
    reset = 1'b0;
  endtask

  task automatic load_bytes(input logic [7:0] b[$], input bit mark_last);
    int unsigned cnt  = 0;
    bit          done = 1'b0;
    bit          acc;
    tick();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    foreach (b[i]) begin
      bus.load_valid = 1'b1;
      bus.load_data  = b[i];
      bus.load_last  = mark_last && (i == b.size() - 1);
      acc = !done;
      ld_q.push_back(acc);
      if (acc) begin
        ref_mem[cnt] = b[i];
        cnt++;
        if (bus.load_last || cnt == 32) done = 1'b1;
      end
      tick();
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    chk("Load_in_after", Load_in, !done);
    chk("load_ready_after", bus.load_ready, !done);
  endtask

  // Starts execution, queues the expected trace and waits until it is consumed.
  task automatic run_prog(input bit az, input int maxn);
    exec_t tr[$];
    bit    halts;
    iss(ref_mem, az, maxn, tr, halts);
    foreach (tr[i]) exp_q.push_back(tr[i]);
    tick();
    run      = 1'b1;
    acc_zero = az;
    tick();
    run = 1'b0;
    for (int k = 0; k < 2 * maxn + 20; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
      #1;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL run_timeout: %0d instructions not seen", exp_q.size());
      exp_q = {};
    end
  endtask

  // Runs a non-halting trace, then asserts reset inside the last EXEC.
  task automatic run_then_reset(input bit az, input int n);
    run_prog(az, n);
    chk("exec_before_rst", (Opcode != 3'd0), 1);
    reset = 1'b1;
    #1;
    chk("rst_exec_Opcode", Opcode, 0);
    chk("rst_exec_pc", pc, 0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] cand [32];
    exec_t      tr[$];
    bit         halts;
    bit         az;
    int         len;

    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;

    do_reset();

    // Three-byte load; run it to confirm contents (0x43, SKZ 0x25, JMP 0).
    q = '{8'h43, 8'h25, 8'hE0};
    load_bytes(q, 1'b1);
    run_then_reset(1'b0, 3);

    // Load op 010 then HLT: halts at pc 1.
    q = '{8'h43, 8'h00};
    load_bytes(q, 1'b1);
    run_prog(1'b0, 10);
    chk("halt_pc", pc, 1);
    chk("halt_flag", halted, 1);

    // SKZ with acc_zero set and clear.
    q = '{8'h20, 8'h00, 8'h00};
    load_bytes(q, 1'b1);
    run_prog(1'b1, 10);
    chk("skz_taken_pc", pc, 2);
    run_prog(1'b0, 10);
    chk("skz_not_taken_pc", pc, 1);

    // Overlong load: only 32 bytes accepted.
    q = {};
    for (int i = 0; i < 40; i++) q.push_back(8'($urandom_range(0, 255)));
    load_bytes(q, 1'b0);

    // Reset in the middle of a load keeps bytes already written.
    q = '{8'h61, 8'h82, 8'hA3, 8'hC4, 8'h00};
    load_bytes(q, 1'b0);
    do_reset();
    run_prog(1'b0, 10);

    // Jump to 31 and wrap back to 0, then replace byte 0 with HLT.
    q = {};
    for (int i = 0; i < 32; i++) q.push_back(8'h00);
    q[0]  = 8'hFF;
    q[31] = 8'h41;
    load_bytes(q, 1'b0);
    run_then_reset(1'b0, 3);
    q = '{8'h00};
    load_bytes(q, 1'b1);
    run_prog(1'b0, 10);
    chk("reload_halt_pc", pc, 0);

    // Random partial reloads of halting programs.
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(1, 32);
      az  = 1'($urandom_range(0, 1));
      for (int tries = 0; tries < 50; tries++) begin
        cand = ref_mem;
        for (int i = 0; i < len; i++)
          cand[i] = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
        iss(cand, az, 40, tr, halts);
        if (halts) break;
      end
      if (!halts) cand[0] = 8'h00;
      q = {};
      for (int i = 0; i < len; i++) q.push_back(cand[i]);
      load_bytes(q, 1'b1);
      run_prog(az, 40);
      chk("rand_halted", halted, 1);
    end

    repeat (3) tick();
    if (ld_q.size() != 0 || exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL leftover: %0d load / %0d exec expectations unused", ld_q.size(), exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
